// File: rtl/cic_serial_pkg.sv
// Shared types and sizing helpers for the CIC sample serializer.
// Default geometry matches the CIC decimator output word.
package cic_serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  localparam int DEF_WIDTH        = 5;
  localparam int DEF_DEPTH        = 4;
  localparam int DEF_CLKS_PER_BIT = 4;

  // Counter width for a range of n values; a range of one still needs one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int BITCNT_W = cnt_w(DEF_CLKS_PER_BIT);
  localparam int IDX_W    = cnt_w(DEF_WIDTH);
  localparam int PTR_W    = cnt_w(DEF_DEPTH);

endpackage

// File: rtl/cic_sample_fifo.sv
// Synchronous FIFO with registered occupancy; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module cic_sample_fifo
  import cic_serial_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_din,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_dout,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_full
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_full;
  logic             w_empty;
  logic             w_pop_ok;
  logic             w_push_ok;

  assign w_full    = (r_level == LW'(DEPTH));
  assign w_empty   = (r_level == '0);
  assign w_pop_ok  = i_pop && !w_empty;
  assign w_push_ok = i_push && (!w_full || w_pop_ok);

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_level = r_level;
  assign o_full  = w_full;

endmodule

// File: rtl/cic_sample_serializer.sv
// Buffers decimated CIC samples and sends each one LSB-first as a
// start/data/stop frame on a single idle-high pin.
module cic_sample_serializer
  import cic_serial_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int DEPTH        = DEF_DEPTH,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       sample_in,
  input  logic                   sample_valid,
  input  logic                   ovf_clr,
  output logic                   tx,
  output logic                   busy,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] level
);

  localparam int CW = cnt_w(CLKS_PER_BIT);
  localparam int IW = cnt_w(WIDTH);

  state_t                 r_state;
  logic [CW-1:0]          r_cnt;
  logic [IW-1:0]          r_idx;
  logic [WIDTH-1:0]       r_shift;
  logic                   r_tx;
  logic                   r_busy;
  logic                   r_ovf;
  logic [WIDTH-1:0]       w_head;
  logic [WIDTH-1:0]       w_shift_nxt;
  logic [$clog2(DEPTH):0] w_level;
  logic                   w_full;
  logic                   w_bit_end;
  logic                   w_pop;
  logic                   w_drop;

  cic_sample_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (sample_valid),
    .i_din   (sample_in),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_level (w_level),
    .o_full  (w_full)
  );

  assign w_bit_end   = (r_cnt == CW'(CLKS_PER_BIT - 1));
  assign w_shift_nxt = r_shift >> 1;
  // Pop only when launching a frame: from IDLE, or at the last STOP cycle.
  assign w_pop  = (w_level != '0) &&
                  ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_bit_end));
  assign w_drop = sample_valid && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_pop)
      r_shift <= w_head;
    else if ((r_state == ST_DATA) && w_bit_end)
      r_shift <= w_shift_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (w_pop) begin
            r_state <= ST_START;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        ST_START: begin
          r_cnt <= w_bit_end ? '0 : r_cnt + CW'(1);
          if (w_bit_end) begin
            r_state <= ST_DATA;
            r_idx   <= '0;
            r_tx    <= r_shift[0];
          end
        end
        ST_DATA: begin
          r_cnt <= w_bit_end ? '0 : r_cnt + CW'(1);
          if (w_bit_end) begin
            if (r_idx == IW'(WIDTH - 1)) begin
              r_state <= ST_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_idx <= r_idx + IW'(1);
              r_tx  <= w_shift_nxt[0];
            end
          end
        end
        ST_STOP: begin
          r_cnt <= w_bit_end ? '0 : r_cnt + CW'(1);
          if (w_bit_end) begin
            if (w_pop) begin
              r_state <= ST_START;
              r_tx    <= 1'b0;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // A new drop outranks a clear arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (rst)          r_ovf <= 1'b0;
    else if (w_drop)  r_ovf <= 1'b1;
    else if (ovf_clr) r_ovf <= 1'b0;
  end

  assign tx       = r_tx;
  assign busy     = r_busy;
  assign overflow = r_ovf;
  assign level    = w_level;

endmodule

// File: tb/tb_cic_sample_serializer.sv
// Directed bench for cic_sample_serializer with WIDTH=5, DEPTH=4,
// CLKS_PER_BIT=4 (28-cycle frames).
module tb_cic_sample_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] sample_in = '0;
  logic       sample_valid = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       tx;
  logic       busy;
  logic       overflow;
  logic [2:0] level;

  int checks = 0;
  int errors = 0;

  logic [4:0] vals [8];
  int         n_vals = 0;

  always #5 clk = ~clk;

  cic_sample_serializer #(
    .WIDTH        (5),
    .DEPTH        (4),
    .CLKS_PER_BIT (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .ovf_clr      (ovf_clr),
    .tx           (tx),
    .busy         (busy),
    .overflow     (overflow),
    .level        (level)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    sample_valid = 1'b0;
    ovf_clr      = 1'b0;
    sample_in    = '0;
    step();
    rst = 1'b0;
  endtask

  // Line level at cycle t of a frame carrying v: start, 5 data bits, stop.
  function automatic logic frame_bit(input logic [4:0] v, input int t);
    if (t < 4)  return 1'b0;
    if (t < 24) return v[(t - 4) / 4];
    return 1'b1;
  endfunction

  function automatic logic exp_tx(input int c, input int start);
    int t;
    t = c - start;
    if (t < 0 || t >= 28 * n_vals) return 1'b1;
    return frame_bit(vals[t / 28], t % 28);
  endfunction

  function automatic logic exp_busy(input int c, input int start);
    return (c >= start) && (c < start + 28 * n_vals);
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b exp 1", tx); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++;
    if (level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
    step();
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_idle tx=%b busy=%b exp tx=1 busy=0", tx, busy);
    end
  endtask

  task automatic test_single();
    do_reset();
    n_vals = 1;
    vals[0] = 5'b10110;
    sample_in = vals[0];
    sample_valid = 1'b1;
    for (int c = 1; c <= 34; c++) begin
      step();
      checks++;
      if (tx !== exp_tx(c, 2)) begin
        errors++; $display("FAIL single_tx c=%0d got %b exp %b", c, tx, exp_tx(c, 2));
      end
      checks++;
      if (busy !== exp_busy(c, 2)) begin
        errors++; $display("FAIL single_busy c=%0d got %b exp %b", c, busy, exp_busy(c, 2));
      end
      if (c == 1) begin
        checks++;
        if (level !== 3'd1) begin errors++; $display("FAIL single_level1 got %0d exp 1", level); end
      end
      if (c == 3) begin
        checks++;
        if (level !== 3'd0) begin errors++; $display("FAIL single_level0 got %0d exp 0", level); end
      end
      sample_valid = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] peak;
    peak = '0;
    do_reset();
    n_vals = 3;
    vals[0] = 5'd1; vals[1] = 5'd2; vals[2] = 5'd3;
    sample_in = 5'd1;
    sample_valid = 1'b1;
    for (int c = 1; c <= 92; c++) begin
      step();
      checks++;
      if (tx !== exp_tx(c, 2)) begin
        errors++; $display("FAIL b2b_tx c=%0d got %b exp %b", c, tx, exp_tx(c, 2));
      end
      checks++;
      if (busy !== exp_busy(c, 2)) begin
        errors++; $display("FAIL b2b_busy c=%0d got %b exp %b", c, busy, exp_busy(c, 2));
      end
      checks++;
      if (overflow !== 1'b0) begin
        errors++; $display("FAIL b2b_overflow c=%0d got %b exp 0", c, overflow);
      end
      if (level > peak) peak = level;
      sample_valid = (c == 2) || (c == 4);
      sample_in    = (c == 2) ? 5'd2 : 5'd3;
    end
    checks++;
    if (peak !== 3'd2) begin errors++; $display("FAIL b2b_peak_level got %0d exp 2", peak); end
  endtask

  task automatic test_overflow();
    do_reset();
    n_vals = 5;
    for (int i = 0; i < 5; i++) vals[i] = 5'(i + 1);
    sample_in = 5'd1;
    sample_valid = 1'b1;
    for (int c = 1; c <= 146; c++) begin
      step();
      checks++;
      if (tx !== exp_tx(c, 2)) begin
        errors++; $display("FAIL ovf_tx c=%0d got %b exp %b", c, tx, exp_tx(c, 2));
      end
      checks++;
      if (busy !== exp_busy(c, 2)) begin
        errors++; $display("FAIL ovf_busy c=%0d got %b exp %b", c, busy, exp_busy(c, 2));
      end
      if (c == 5) begin
        checks++;
        if (level !== 3'd4) begin errors++; $display("FAIL ovf_level_full got %0d exp 4", level); end
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got %b exp 0", overflow); end
      end
      if (c == 6) begin
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", overflow); end
        checks++;
        if (level !== 3'd4) begin errors++; $display("FAIL ovf_level_after got %0d exp 4", level); end
      end
      if (c == 146) begin
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", overflow); end
      end
      sample_valid = (c <= 5);
      sample_in    = 5'(c + 1);
    end
  endtask

  task automatic test_collision();
    do_reset();
    n_vals = 6;
    for (int i = 0; i < 5; i++) vals[i] = 5'(i + 1);
    vals[5] = 5'd7;
    sample_in = 5'd1;
    sample_valid = 1'b1;
    for (int c = 1; c <= 175; c++) begin
      step();
      checks++;
      if (tx !== exp_tx(c, 2)) begin
        errors++; $display("FAIL coll_tx c=%0d got %b exp %b", c, tx, exp_tx(c, 2));
      end
      checks++;
      if (busy !== exp_busy(c, 2)) begin
        errors++; $display("FAIL coll_busy c=%0d got %b exp %b", c, busy, exp_busy(c, 2));
      end
      if (c == 29) begin
        checks++;
        if (level !== 3'd4) begin errors++; $display("FAIL coll_level_pre got %0d exp 4", level); end
      end
      if (c == 30) begin
        checks++;
        if (level !== 3'd4) begin errors++; $display("FAIL coll_level_post got %0d exp 4", level); end
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL coll_overflow got %b exp 0", overflow); end
      end
      if (c == 175) begin
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL coll_overflow_end got %b exp 0", overflow); end
      end
      sample_valid = (c <= 4) || (c == 29);
      sample_in    = (c == 29) ? 5'd7 : 5'(c + 1);
    end
  endtask

  task automatic test_ovf_clear();
    do_reset();
    sample_in = 5'd9;
    sample_valid = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      step();
      if (c == 6) begin
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL clr_pre got %b exp 1", overflow); end
      end
      if (c == 7) begin
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL clr_vs_set got %b exp 1", overflow); end
        checks++;
        if (level !== 3'd4) begin errors++; $display("FAIL clr_level got %0d exp 4", level); end
      end
      if (c >= 8) begin
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL clr_alone c=%0d got %b exp 0", c, overflow); end
      end
      sample_valid = (c <= 6);
      sample_in    = 5'(c + 9);
      ovf_clr      = (c == 6) || (c == 7);
    end
    ovf_clr = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    sample_in = 5'd1;
    sample_valid = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      step();
      if (c == 10) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before got %b exp 1", busy); end
        checks++;
        if (level !== 3'd2) begin errors++; $display("FAIL mid_level_before got %0d exp 2", level); end
      end
      if (c == 11) begin
        checks++;
        if (level !== 3'd0) begin errors++; $display("FAIL mid_level got %0d exp 0", level); end
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL mid_overflow got %b exp 0", overflow); end
      end
      if (c >= 11) begin
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL mid_tx c=%0d got %b exp 1", c, tx); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy c=%0d got %b exp 0", c, busy); end
      end
      sample_valid = (c <= 2);
      sample_in    = 5'(c + 1);
      rst          = (c == 10);
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_collision();
    test_ovf_clear();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
